instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries; legal values 2..4.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 imem_en  output  1  read enable to instruction memory.
REQ-006 pc_addr  output  32  byte address to instruction memory; memory indexes word [12:2].
REQ-007 instr_in  input  32  memory read data; valid in the cycle after imem_en=1.
REQ-008 redirect_valid  input  1  single-cycle pulse: branch/jump/trap redirect.
REQ-009 redirect_pc  input  32  redirect target; sampled only when redirect_valid=1.
REQ-010 id_valid  output  1  instruction available to decode.
REQ-011 id_instr  output  32  instruction word at buffer head.
REQ-012 id_pc  output  32  byte address of id_instr.
REQ-013 id_ready  input  1  decode accepts; transfer when id_valid && id_ready.

Function
REQ-014 FSM states: BOOT (first cycle after reset release, no issue) and RUN; BOOT->RUN unconditionally after one cycle; RUN has no exit except reset.
REQ-015 In RUN without redirect: imem_en = (count + inflight - pop) < BUF_DEPTH; pop = id_valid && id_ready; pc_addr = pc_reg.
REQ-016 Each issue SHALL advance pc_reg by 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0) and set inflight=1 with a captured tag PC.
REQ-017 When inflight=1 and not squashed, instr_in and tag PC SHALL be pushed into the buffer at the next edge.
REQ-018 Issue-to-id_valid latency SHALL be 2 cycles with empty buffer; sustained throughput 1 instr/cycle with id_ready held high.
REQ-019 Buffer SHALL be FIFO-ordered; id_instr/id_pc SHALL be stable while id_valid=1 and id_ready=0.
REQ-020 Buffer full: no issue (REQ-015); no response SHALL ever be dropped or overwritten.
REQ-021 Buffer empty: id_valid=0; id_instr/id_pc don't-care.
REQ-022 Redirect (any state): same cycle imem_en=1, pc_addr = {redirect_pc[31:2],2'b00}, id_valid forced 0 (no handshake); at edge buffer flushed, any outstanding response squashed, pc_reg <= target+4, inflight set for target, state RUN.
REQ-023 Redirect with buffer full or with response in flight: flush SHALL take priority; squashed data SHALL never reach decode.
REQ-024 Back-to-back redirects: each SHALL supersede the previous; only the last target's stream is delivered.
REQ-025 redirect_pc[1:0] SHALL be ignored (forced to 0).

Reset
REQ-026 While rst=1: state=BOOT, pc_reg=RESET_PC, count=0, inflight=0, imem_en=0, pc_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0.
REQ-027 rst asserted mid-operation SHALL clear all state immediately (asynchronously); a response arriving after release SHALL be ignored.
REQ-028 First fetch SHALL be RESET_PC, issued in the second cycle after reset release.

Structure
REQ-029 Shared package core_pkg SHALL hold XLEN=32, RESET_PC default, NOP encoding 32'h0000_0013, and the fetch state enumeration.
REQ-030 Buffer SHALL be a sub-module fetch_fifo (depth BUF_DEPTH, 64-bit entry {pc,instr}, synchronous flush input).

Verification
REQ-031 Reset release, id_ready=1, memory word k = 32'h1000_0000+k: pc_addr 0,4,8,... one per cycle; id_valid first high 3 cycles after release with id_pc=0, id_instr=32'h1000_0000; continuous thereafter.
REQ-032 id_ready=0 for 10 cycles: exactly BUF_DEPTH entries buffered, imem_en low, no loss; on id_ready=1 order resumes with id_pc 0,4,8,... contiguous.
REQ-033 Redirect to 32'h0000_0100 while buffer full and response in flight: id_valid low that cycle, next delivered id_pc=32'h100, none of the older PCs appear.
REQ-034 Redirect to 32'h0000_0203: pc_addr=32'h200, delivered id_pc=32'h200 then 32'h204.
REQ-035 Redirects on two consecutive cycles (0x40, 0x80): only 0x80, 0x84,... delivered.
REQ-036 rst pulsed mid-stream with id_ready=0 and full buffer: outputs cleared without clock edge; restart at RESET_PC per REQ-028.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: data width, reset vector, NOP encoding, fetch FSM states.
// No logic of its own, so no latency.
// No flow control of its own, so no backpressure.
package core_pkg;

   localparam int              XLEN             = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

   typedef enum logic {
      FETCH_BOOT = 1'b0,
      FETCH_RUN  = 1'b1
   } fetch_state_e;

   // One fetched instruction together with the byte address it came from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // The fetch path only handles word-aligned addresses.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: small FIFO of {pc,instr} entries with a synchronous flush.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller only pushes when it has reserved a slot.
module fetch_fifo
   import core_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_dat,
   input  logic             pop,
   output fetch_entry_t     head_dat,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_pop;

   // DEPTH need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   // Head is zeroed when empty so the outputs are clean out of reset.
   assign head_dat = empty ? '0 : mem_q[rd_ptr];

   // Storage write; data needs no reset since the count gates visibility.
   always_ff @(posedge clk) begin
      if (push && !flush)
         mem_q[wr_ptr] <= push_dat;
   end

   // Pointer and occupancy tracking; flush empties the buffer in one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)
            rd_ptr <= next_ptr(rd_ptr);
         case ({push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues sequential word reads, buffers responses, serves decode in order.
// Latency: 2 cycles from issue to id_valid with an empty buffer; 1 instr/cycle sustained.
// Backpressure: id_ready low fills the buffer; issue stops once buffer plus in-flight reach BUF_DEPTH.
module instr_fetch
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_en,
   output logic [XLEN-1:0] pc_addr,
   input  logic [XLEN-1:0] instr_in,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   input  logic            id_ready
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   fetch_state_e     state;
   logic [XLEN-1:0]  pc_reg;
   logic [XLEN-1:0]  tag_pc;
   logic             inflight;

   logic             redir;
   logic [XLEN-1:0]  redir_tgt;
   logic             pop;
   logic             push;
   logic [3:0]       occ;
   logic [CNT_W-1:0] fifo_cnt;
   logic             fifo_empty;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;

   // Reset dominates a redirect so the outputs read as cleared while rst is high.
   assign redir     = redirect_valid && !rst;
   assign redir_tgt = word_align(redirect_pc);

   // A redirect hides the head so stale instructions never hand off that cycle.
   assign id_valid  = !fifo_empty && !redir;
   assign id_instr  = head.instr;
   assign id_pc     = head.pc;
   assign pop       = id_valid && id_ready;

   // Responses in flight during a redirect belong to the old stream and are dropped.
   assign push       = inflight && !redir;
   assign push_entry = '{pc: tag_pc, instr: instr_in};

   // Slots committed after this cycle's pop; an issue is allowed only if one remains.
   assign occ = 4'(fifo_cnt) + 4'(inflight) - 4'(pop);

   // Memory request: redirect target takes the port immediately, else sequential fetch in RUN.
   always_comb begin
      imem_en = 1'b0;
      pc_addr = pc_reg;
      if (redir) begin
         imem_en = 1'b1;
         pc_addr = redir_tgt;
      end else if (state == FETCH_RUN) begin
         imem_en = (occ < 4'(BUF_DEPTH));
      end
   end

   // Fetch FSM, PC advance and in-flight tracking; BOOT spends one idle cycle after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FETCH_BOOT;
         pc_reg   <= RESET_PC;
         tag_pc   <= '0;
         inflight <= 1'b0;
      end else begin
         state <= FETCH_RUN;
         if (redir) begin
            pc_reg   <= redir_tgt + XLEN'(4);
            tag_pc   <= redir_tgt;
            inflight <= 1'b1;
         end else if (imem_en) begin
            pc_reg   <= pc_reg + XLEN'(4);
            tag_pc   <= pc_reg;
            inflight <= 1'b1;
         end else begin
            inflight <= 1'b0;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .flush    (redir),
      .push     (push),
      .push_dat (push_entry),
      .pop      (pop),
      .head_dat (head),
      .count    (fifo_cnt),
      .empty    (fifo_empty)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a random phase, checked against a stream scoreboard.
// The scoreboard tracks the expected issue address, expected delivered PC and outstanding work.
// The memory model answers one cycle after each enable; non-enabled cycles carry garbage.
module tb_instr_fetch;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_en;
   logic [31:0] pc_addr;
   logic [31:0] instr_in;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_ready;

   always #5 clk = ~clk;

   instr_fetch #(
      .RESET_PC  (RPC),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_en        (imem_en),
      .pc_addr        (pc_addr),
      .instr_in       (instr_in),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_ready       (id_ready)
   );

   int tests = 0;
   int fails = 0;

   // Stream model.
   logic [31:0] exp_issue;
   logic [31:0] exp_deliver;
   int          outstanding;
   int          cyc;
   int          first_vld;

   // Samples taken at the falling edge.
   logic        s_en;
   logic        s_vld;
   logic [31:0] s_addr;
   logic [31:0] s_pc;
   logic [31:0] s_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 + {21'd0, a[12:2]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_issue   = RPC;
      exp_deliver = RPC;
      outstanding = 0;
      cyc         = 0;
      first_vld   = -1;
   endtask

   // One clock cycle: sample and check at negedge, then answer memory just after posedge.
   task automatic tick();
      logic [31:0] tgt;
      @(negedge clk);
      s_en    = imem_en;
      s_vld   = id_valid;
      s_addr  = pc_addr;
      s_pc    = id_pc;
      s_instr = id_instr;
      if (redirect_valid) begin
         tgt = {redirect_pc[31:2], 2'b00};
         chk("redir_id_valid", 32'(s_vld), 32'd0);
         chk("redir_imem_en", 32'(s_en), 32'd1);
         chk("redir_pc_addr", s_addr, tgt);
         exp_issue   = tgt + 32'd4;
         exp_deliver = tgt;
         outstanding = 1;
      end else begin
         if (s_vld) begin
            if (first_vld < 0)
               first_vld = cyc;
            chk("id_pc_order", s_pc, exp_deliver);
            chk("id_instr_data", s_instr, mem_word(exp_deliver));
            if (id_ready) begin
               exp_deliver = exp_deliver + 32'd4;
               outstanding--;
            end
         end
         if (s_en) begin
            chk("issue_addr", s_addr, exp_issue);
            exp_issue = exp_issue + 32'd4;
            outstanding++;
            chk("outstanding_bound", 32'(outstanding <= DEPTH), 32'd1);
         end
      end
      @(posedge clk);
      #1;
      instr_in = s_en ? mem_word(s_addr) : 32'($urandom());
      cyc++;
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      #2;
      chk("rst_imem_en", 32'(imem_en), 32'd0);
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_pc_addr", pc_addr, RPC);
      chk("rst_id_pc", id_pc, 32'd0);
      chk("rst_id_instr", id_instr, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      instr_in = $urandom();
      model_reset();
   endtask

   // Bounded wait for the next id_valid; returns cycles spent.
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!s_vld && n < 10);
   endtask

   task automatic redirect(input logic [31:0] tgt);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      tick();
      redirect_valid = 1'b0;
   endtask

   initial begin
      int n;
      rst            = 1'b1;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_in       = '0;
      model_reset();
      do_reset();

      // Boot cycle idle, first fetch in the next cycle, then streaming.
      tick();
      chk("boot_no_issue", 32'(s_en), 32'd0);
      tick();
      chk("first_fetch_en", 32'(s_en), 32'd1);
      chk("first_fetch_addr", s_addr, RPC);
      for (int k = 2; k < 16; k++) begin
         tick();
         if (k >= 3)
            chk("stream_vld", 32'(s_vld), 32'd1);
      end
      chk("first_valid_cycle", 32'(first_vld), 32'd3);

      // Decode stall fills the buffer and stops issue.
      id_ready = 1'b0;
      repeat (10) tick();
      chk("stall_no_issue", 32'(s_en), 32'd0);
      chk("stall_buffered", 32'(outstanding), 32'(DEPTH));
      chk("stall_vld", 32'(s_vld), 32'd1);

      // Redirect with a full buffer: old entries flushed.
      id_ready = 1'b1;
      redirect(32'h0000_0100);
      wait_valid(n);
      chk("redir100_latency", 32'(n), 32'd2);
      chk("redir100_pc", s_pc, 32'h0000_0100);

      // Redirect while streaming (response in flight), misaligned target.
      repeat (5) tick();
      redirect(32'h0000_0203);
      wait_valid(n);
      chk("redir203_pc0", s_pc, 32'h0000_0200);
      tick();
      chk("redir203_vld1", 32'(s_vld), 32'd1);
      chk("redir203_pc1", s_pc, 32'h0000_0204);

      // Back-to-back redirects: only the last one survives.
      redirect(32'h0000_0040);
      redirect(32'h0000_0080);
      wait_valid(n);
      chk("b2b_latency", 32'(n), 32'd2);
      chk("b2b_pc", s_pc, 32'h0000_0080);
      repeat (4) tick();

      // PC wraps from the top of the address space to zero.
      redirect(32'hFFFF_FFF8);
      wait_valid(n);
      chk("wrap_pc0", s_pc, 32'hFFFF_FFF8);
      repeat (2) tick();
      chk("wrap_pc2", s_pc, 32'h0000_0000);

      // Random backpressure and redirects.
      for (int i = 0; i < 400; i++) begin
         id_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom();
         end else begin
            redirect_valid = 1'b0;
         end
         tick();
      end
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      repeat (6) tick();

      // Mid-stream reset with a full buffer, then restart from the reset vector.
      id_ready = 1'b0;
      repeat (8) tick();
      chk("prerst_full", 32'(outstanding), 32'(DEPTH));
      do_reset();
      id_ready = 1'b1;
      tick();
      chk("rerun_boot_no_issue", 32'(s_en), 32'd0);
      tick();
      chk("rerun_first_addr", s_addr, RPC);
      wait_valid(n);
      chk("rerun_first_valid_cycle", 32'(first_vld), 32'd3);
      chk("rerun_first_pc", s_pc, RPC);
      repeat (6) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
